// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator: shared prescaler and period counter, per-channel
// double-buffered duty with optional ramp slewing applied at each period boundary.
module servo_pwm_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 12,
    parameter int DUTY_W    = 8,
    parameter int PRE_W     = 16,
    parameter int MIN_PULSE = 64,
    parameter int RAMP_STEP = 1,
    parameter int AW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PRE_W-1:0]    prescale,
    input  logic [CNT_W-1:0]    endcount,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DUTY_W-1:0]   wr_data,
    input  logic [CHANNELS-1:0] ramp_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic [CHANNELS-1:0] settled
);

    localparam int SUM_W = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 1;

    logic [PRE_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  counter;
    logic [DUTY_W-1:0] target [CHANNELS];
    logic [DUTY_W-1:0] active [CHANNELS];
    logic              tick;
    logic              wrap;
    logic [31:0]       wr_idx;

    // Pulse length in ticks, kept one bit wider than either operand so it never wraps.
    function automatic logic [SUM_W-1:0] pulse_len(input logic [DUTY_W-1:0] duty);
        return SUM_W'(MIN_PULSE) + SUM_W'(duty);
    endfunction

    // Move toward the target by at most RAMP_STEP, landing exactly on it when closer.
    function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] diff;
        logic [DUTY_W-1:0] result;
        result = tgt;
        if (cur < tgt) begin
            diff = tgt - cur;
            if (32'(diff) > 32'(RAMP_STEP))
                result = cur + DUTY_W'(RAMP_STEP);
        end else if (cur > tgt) begin
            diff = cur - tgt;
            if (32'(diff) > 32'(RAMP_STEP))
                result = cur - DUTY_W'(RAMP_STEP);
        end
        return result;
    endfunction

    assign tick   = enable && (pre_cnt == prescale);
    assign wrap   = tick && (counter >= endcount);
    assign wr_idx = 32'(wr_addr);

    // Timebase stage: prescaler, period counter and the boundary strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_cnt      <= '0;
            counter      <= '0;
            period_start <= 1'b0;
        end else if (!enable) begin
            pre_cnt      <= '0;
            counter      <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
            period_start <= wrap;
            if (tick)
                counter <= (counter >= endcount) ? '0 : counter + 1'b1;
        end
    end

    // Channel stage: duty buffers and the registered compare against the counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                active[i] <= '0;
            end
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_idx == 32'(i)))
                    target[i] <= wr_data;
                if (wrap)
                    active[i] <= ramp_en[i] ? ramp_toward(active[i], target[i]) : target[i];
                pwm_out[i] <= enable && (SUM_W'(counter) < pulse_len(active[i]));
            end
        end
    end

    always_comb begin
        settled = '0;
        for (int i = 0; i < CHANNELS; i++)
            settled[i] = (active[i] == target[i]);
    end

endmodule
